// File: rtl/rpn_sequencer.sv
// RPN token sequencer: turns operand/operator tokens into push/pop strobes on an
// external stack, evaluates binary operators and reports underflow/overflow/illegal-op.
module rpn_sequencer #(
   parameter int DW    = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tok_valid,
   input  logic                     tok_is_op,
   input  logic [DW-1:0]            tok_dat,
   input  logic [2:0]               tok_op,
   output logic                     tok_ready,
   output logic                     stk_push_stb,
   output logic [DW-1:0]            stk_push_dat,
   output logic                     stk_pop_stb,
   input  logic [DW-1:0]            stk_pop_dat,
   output logic                     res_stb,
   output logic [DW-1:0]            res_dat,
   output logic                     err_stb,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH):0]   depth
);

   localparam int             AW        = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0]  FULL      = AW'(DEPTH);
   localparam logic [AW-1:0]  ONE       = AW'(1);
   localparam logic [AW-1:0]  TWO       = AW'(2);
   localparam logic [1:0]     ERR_UNDER = 2'b01;
   localparam logic [1:0]     ERR_OVER  = 2'b10;
   localparam logic [1:0]     ERR_ILL   = 2'b11;

   typedef enum logic [2:0] {IDLE, PUSH_D, POP_B, POP_A, PUSH_R} state_t;

   state_t          state, state_next;
   logic            armed;
   logic            push_stb, push_stb_next;
   logic            pop_stb, pop_stb_next;
   logic            res_stb_r, res_stb_next;
   logic            err_stb_r, err_stb_next;
   logic [1:0]      err_code_r, err_code_next;
   logic [DW-1:0]   push_dat, push_dat_next;
   logic [DW-1:0]   res_dat_r, res_dat_next;
   logic [DW-1:0]   a_reg, a_next;
   logic [DW-1:0]   b_reg, b_next;
   logic [2:0]      op_reg, op_next;
   logic [AW-1:0]   depth_reg, depth_next;
   logic [DW-1:0]   alu_out;
   logic            accept;

   function automatic logic [DW-1:0] alu(input logic [2:0] op,
                                         input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
      logic [DW-1:0] r;
      case (op)
         3'd0:    r = x + y;
         3'd1:    r = x - y;
         3'd2:    r = x * y;
         3'd3:    r = x & y;
         3'd4:    r = x | y;
         3'd5:    r = x ^ y;
         default: r = '0;
      endcase
      return r;
   endfunction

   // armed keeps tok_ready low until the first edge after reset release
   assign tok_ready = (state == IDLE) && armed;
   assign accept    = tok_valid && tok_ready;
   assign alu_out   = alu(op_reg, stk_pop_dat, b_reg);

   always_comb begin
      state_next    = state;
      push_stb_next = 1'b0;
      pop_stb_next  = 1'b0;
      res_stb_next  = 1'b0;
      err_stb_next  = 1'b0;
      err_code_next = err_code_r;
      push_dat_next = push_dat;
      res_dat_next  = res_dat_r;
      a_next        = a_reg;
      b_next        = b_reg;
      op_next       = op_reg;
      // depth tracks the strobes actually seen by the stack this cycle
      depth_next    = depth_reg;
      if (push_stb)
         depth_next = depth_reg + ONE;
      else if (pop_stb)
         depth_next = depth_reg - ONE;

      case (state)
         IDLE: begin
            if (accept) begin
               if (!tok_is_op) begin
                  if (depth_reg == FULL) begin
                     err_stb_next  = 1'b1;
                     err_code_next = ERR_OVER;
                  end else begin
                     state_next    = PUSH_D;
                     push_stb_next = 1'b1;
                     push_dat_next = tok_dat;
                  end
               end else if (tok_op > 3'd5) begin
                  err_stb_next  = 1'b1;
                  err_code_next = ERR_ILL;
               end else if (depth_reg < TWO) begin
                  err_stb_next  = 1'b1;
                  err_code_next = ERR_UNDER;
               end else begin
                  state_next   = POP_B;
                  pop_stb_next = 1'b1;
                  op_next      = tok_op;
               end
            end
         end
         PUSH_D: state_next = IDLE;
         POP_B: begin
            b_next       = stk_pop_dat;
            pop_stb_next = 1'b1;
            state_next   = POP_A;
         end
         POP_A: begin
            a_next        = stk_pop_dat;
            push_stb_next = 1'b1;
            push_dat_next = alu_out;
            res_stb_next  = 1'b1;
            res_dat_next  = alu_out;
            state_next    = PUSH_R;
         end
         PUSH_R: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         armed      <= 1'b0;
         push_stb   <= 1'b0;
         pop_stb    <= 1'b0;
         res_stb_r  <= 1'b0;
         err_stb_r  <= 1'b0;
         err_code_r <= '0;
         push_dat   <= '0;
         res_dat_r  <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         depth_reg  <= '0;
      end else begin
         state      <= state_next;
         armed      <= 1'b1;
         push_stb   <= push_stb_next;
         pop_stb    <= pop_stb_next;
         res_stb_r  <= res_stb_next;
         err_stb_r  <= err_stb_next;
         err_code_r <= err_code_next;
         push_dat   <= push_dat_next;
         res_dat_r  <= res_dat_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         op_reg     <= op_next;
         depth_reg  <= depth_next;
      end
   end

   assign stk_push_stb = push_stb;
   assign stk_push_dat = push_dat;
   assign stk_pop_stb  = pop_stb;
   assign res_stb      = res_stb_r;
   assign res_dat      = res_dat_r;
   assign err_stb      = err_stb_r;
   assign err_code     = err_code_r;
   assign depth        = depth_reg;

endmodule
